// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and word/padding constants for the instruction-memory loader
package imem_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;
  localparam logic [7:0] NOP_BYTE = 8'h00;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream valid/data/last/ready; master = byte source, slave = loader
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;
  modport master (output byte_valid, byte_data, byte_last, input byte_ready);
  modport slave (input byte_valid, byte_data, byte_last, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams bytes (src) into imem via registered mem_we/mem_addr/mem_wdata, pads to a word, holds cpu while busy
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      src,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count
);
  state_t state, state_n;
  logic [ADDR_W-1:0] wptr;
  logic accept, pad, begin_load, last_slot, word_end;
  assign accept     = src.byte_valid && src.byte_ready;
  assign pad        = state == PAD;
  assign begin_load = start && (state == IDLE || state == DONE);
  assign last_slot  = wptr == ADDR_W'(MEM_BYTES - 1);
  assign word_end   = wptr[1:0] == 2'(WORD_BYTES - 1);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? LOAD : state;
      LOAD: state_n = !accept ? LOAD : src.byte_last ? (word_end ? DONE : PAD) : last_slot ? DONE : LOAD;
      PAD: state_n = word_end ? DONE : PAD;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    src.byte_ready = state == LOAD;
    done           = state == DONE;
    busy           = state == LOAD || state == PAD || mem_we;
    cpu_hold       = busy;
  end
  always_ff @(posedge clk)
    if (reset) begin
      wptr       <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= accept || pad;
      if (begin_load) begin
        wptr       <= '0;
        byte_count <= '0;
        overflow   <= 1'b0;
      end
      if (accept || pad) begin
        mem_addr  <= wptr;
        mem_wdata <= pad ? NOP_BYTE : src.byte_data;
        wptr      <= last_slot ? wptr : wptr + 1'b1;
      end
      if (accept) begin
        byte_count <= byte_count + 1'b1;
        if (!src.byte_last && last_slot) overflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus against a cycle-stamped write-list model of the loader
module tb_imem_loader;
  localparam int BIG = 1 << 30;
  typedef struct {
    int         addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;
  logic clk = 0, reset = 1, start = 0;
  logic mem_we, busy, cpu_hold, done, overflow;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [9:0] byte_count;
  imem_loader_if src();
  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .src(src),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
    .byte_count(byte_count)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int nvec = 0, nerr = 0;
  bit chk = 0;
  wr_t q[$];
  logic [7:0] mem [512];
  int wp = 0;
  logic m_ready = 0, n_ready = 0, m_ovf = 0, n_ovf = 0;
  int m_cnt = 0, n_cnt = 0;
  int done_at = BIG, n_done_at = BIG, busy_until = -1, n_busy_until = -1;
  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", n, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (chk) begin : compare
    logic ew;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      cmp("missed_write", 32'(q[0].addr), 32'hFFFF_FFFF);
      void'(q.pop_front());
    end
    ew = q.size() > 0 && q[0].cyc == cyc;
    cmp("mem_we", 32'(mem_we), 32'(ew));
    if (ew) begin
      cmp("mem_addr", 32'(mem_addr), 32'(q[0].addr));
      cmp("mem_wdata", 32'(mem_wdata), 32'(q[0].data));
      void'(q.pop_front());
    end
    if (mem_we) mem[mem_addr] = mem_wdata;
    cmp("byte_ready", 32'(src.byte_ready), 32'(m_ready));
    cmp("busy", 32'(busy), 32'(m_ready || cyc <= busy_until));
    cmp("cpu_hold", 32'(cpu_hold), 32'(m_ready || cyc <= busy_until));
    cmp("done", 32'(done), 32'(cyc >= done_at));
    cmp("overflow", 32'(overflow), 32'(m_ovf));
    cmp("byte_count", 32'(byte_count), 32'(m_cnt));
  end
  task automatic tick(input logic rs, input logic st, input logic v, input logic [7:0] d, input logic l);
    int fin;
    @(posedge clk);
    #1;
    m_ready = n_ready;
    m_cnt = n_cnt;
    m_ovf = n_ovf;
    done_at = n_done_at;
    busy_until = n_busy_until;
    reset = rs;
    start = st;
    src.byte_valid = v;
    src.byte_data = d;
    src.byte_last = l;
    if (rs) begin
      n_ready = 0;
      n_cnt = 0;
      n_ovf = 0;
      n_done_at = BIG;
      n_busy_until = -1;
      wp = 0;
      while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    end else begin
      if (st && !m_ready && cyc >= busy_until) begin
        n_ready = 1;
        n_cnt = 0;
        n_ovf = 0;
        n_done_at = BIG;
        wp = 0;
      end
      if (v && m_ready) begin
        q.push_back(wr_t'{addr: wp, data: d, cyc: cyc + 1});
        wp++;
        n_cnt++;
        if (l) begin
          fin = cyc + 1;
          while (wp % 4 != 0) begin
            fin++;
            q.push_back(wr_t'{addr: wp, data: 8'h00, cyc: fin});
            wp++;
          end
          n_ready = 0;
          n_done_at = fin;
          n_busy_until = fin;
        end else if (wp == 512) begin
          n_ready = 0;
          n_ovf = 1;
          n_done_at = cyc + 1;
          n_busy_until = cyc + 1;
        end
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 8'h00, 0);
  endtask
  task automatic go();
    tick(0, 1, 0, 8'h00, 0);
  endtask
  task automatic send(input logic v, input logic [7:0] d, input logic l);
    tick(0, 0, v, d, l);
  endtask
  logic [7:0] aligned [8] = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
  logic bp_valid [7] = '{1, 0, 0, 1, 1, 0, 1};
  initial begin
    int k;
    src.byte_valid = 0;
    src.byte_data = 0;
    src.byte_last = 0;
    tick(1, 0, 0, 8'h00, 0);
    tick(1, 0, 0, 8'h00, 0);
    chk = 1;
    idle(1);
    @(negedge clk);
    cmp("rst_mem_we", 32'(mem_we), 0);
    cmp("rst_mem_addr", 32'(mem_addr), 0);
    cmp("rst_mem_wdata", 32'(mem_wdata), 0);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_ready", 32'(src.byte_ready), 0);
    cmp("rst_done", 32'(done), 0);
    // padding: 5 bytes, last word filled with NOPs
    go();
    for (int i = 0; i < 5; i++) send(1, 8'hAA + 8'(i), i == 4);
    idle(5);
    @(negedge clk);
    cmp("pad_mem4", 32'(mem[4]), 32'hAE);
    cmp("pad_mem5", 32'(mem[5]), 0);
    cmp("pad_mem6", 32'(mem[6]), 0);
    cmp("pad_mem7", 32'(mem[7]), 0);
    cmp("pad_count", 32'(byte_count), 5);
    cmp("pad_done", 32'(done), 1);
    // aligned 8-byte load
    go();
    for (int i = 0; i < 8; i++) send(1, aligned[i], i == 7);
    idle(1);
    @(negedge clk);
    cmp("al_last_addr", 32'(mem_addr), 7);
    cmp("al_hold_last", 32'(cpu_hold), 1);
    idle(1);
    @(negedge clk);
    cmp("al_hold_fall", 32'(cpu_hold), 0);
    cmp("al_count", 32'(byte_count), 8);
    cmp("al_mem3", 32'(mem[3]), 32'h05);
    // backpressure
    go();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      send(bp_valid[i], 8'h11 * 8'(k + 1), bp_valid[i] && k == 3);
      if (bp_valid[i]) k++;
    end
    idle(3);
    @(negedge clk);
    cmp("bp_mem2", 32'(mem[2]), 32'h33);
    cmp("bp_count", 32'(byte_count), 4);
    // overflow: 513 bytes, no last
    go();
    for (int i = 0; i < 513; i++) send(1, 8'(i), 0);
    idle(1);
    @(negedge clk);
    cmp("ov_flag", 32'(overflow), 1);
    cmp("ov_done", 32'(done), 1);
    cmp("ov_count", 32'(byte_count), 512);
    cmp("ov_ready", 32'(src.byte_ready), 0);
    cmp("ov_mem511", 32'(mem[511]), 32'hFF);
    cmp("ov_mem300", 32'(mem[300]), 32'd44);
    // reset after 3 accepts, then reload
    go();
    for (int i = 0; i < 3; i++) send(1, 8'hC0 + 8'(i), 0);
    tick(1, 0, 0, 8'h00, 0);
    idle(1);
    @(negedge clk);
    cmp("mr_mem_we", 32'(mem_we), 0);
    cmp("mr_count", 32'(byte_count), 0);
    cmp("mr_busy", 32'(busy), 0);
    cmp("mr_ovf", 32'(overflow), 0);
    go();
    for (int i = 0; i < 4; i++) send(1, 8'h51 + 8'(i), i == 3);
    idle(2);
    @(negedge clk);
    cmp("mr_mem0", 32'(mem[0]), 32'h51);
    cmp("mr_done", 32'(done), 1);
    // restart from DONE
    go();
    idle(1);
    @(negedge clk);
    cmp("rs_done_clr", 32'(done), 0);
    for (int i = 0; i < 4; i++) send(1, 8'h61 + 8'(i), i == 3);
    idle(2);
    @(negedge clk);
    cmp("rs_mem3", 32'(mem[3]), 32'h64);
    cmp("rs_count", 32'(byte_count), 4);
    cmp("q_drained", 32'(q.size()), 0);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the byte-wide instruction memory from a byte stream before the pipeline runs. It is the write side of the instruction-memory read port used by the fetch stage. It accepts bytes over a valid/ready handshake and writes them to consecutive addresses from 0. If the final program length is not a multiple of 4, it pads the last word with 0x00 bytes so the word is a NOP. While loading, it asserts `cpu_hold` to keep the PC, nPC and pipeline stages in reset.

## Interface
Parameters:
- `ADDR_W`, 9, instruction-memory byte address width
- `MEM_BYTES`, 512, memory depth in bytes; must be a multiple of 4 and ≤ 2^ADDR_W

Ports:
- `clk`  in  1  clock; everything is on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a load
- `byte_valid`  in  1  source has a byte
- `byte_data`  in  8  program byte, in memory order (big-endian words)
- `byte_last`  in  1  qualifies the final byte of the program
- `byte_ready`  out  1  loader accepts a byte this cycle
- `mem_we`  out  1  instruction-memory write strobe
- `mem_addr`  out  ADDR_W  write byte address
- `mem_wdata`  out  8  write byte
- `busy`  out  1  load in progress
- `cpu_hold`  out  1  ORed into the pipeline reset; equals `busy`
- `done`  out  1  load finished; held until the next `start` or `reset`
- `overflow`  out  1  memory filled without `byte_last`; held until the next `start` or `reset`
- `byte_count`  out  ADDR_W+1  data bytes accepted; padding is not counted

## Operation
The loader is a state machine with four states: IDLE, LOAD, PAD and DONE.
- **Accept rule:** a byte is accepted on a cycle where `byte_valid && byte_ready`.
- **IDLE:** `byte_ready` is 0.
  - `start` moves to LOAD and clears the write pointer `wptr`, `byte_count`, `done` and `overflow`.
- **LOAD:** `byte_ready` is 1.
  - On accept: register a write of `byte_data` at `wptr`, increment `wptr` and increment `byte_count`.
  - Accept with `byte_last` and `(wptr+1) mod 4 == 0`: go to DONE.
  - Accept with `byte_last` and `(wptr+1) mod 4 != 0`: go to PAD.
  - Accept without `byte_last` and `wptr == MEM_BYTES-1`: set `overflow` and go to DONE.
  - Accept with `byte_last` and `wptr == MEM_BYTES-1`: go to DONE normally, with no overflow.
- **PAD:** `byte_ready` is 0.
  - Each cycle, register a write of 0x00 at `wptr` and increment `wptr`.
  - When the padded byte has `wptr mod 4 == 3`, go to DONE.
- **DONE:** `byte_ready` is 0 and `done` is 1.
  - `start` moves to LOAD and clears `done` and `overflow`.
- `start` is ignored in LOAD and PAD.
- `byte_valid` is ignored outside LOAD.
- `busy` is 1 when the state is LOAD or PAD, or when `mem_we` is 1. This keeps `cpu_hold` up through the last write.
- Address width: `wptr` is ADDR_W bits and never wraps; the overflow exit prevents it.
- `byte_count` saturates naturally at MEM_BYTES.

## Timing
- **Reset values:**
  - State IDLE.
  - `byte_ready`, `mem_we`, `busy`, `cpu_hold`, `done`, `overflow` all 0.
  - `mem_addr`, `mem_wdata`, `byte_count` all 0.
- **Write latency:** a byte accepted in cycle N appears as `mem_we=1` with its `mem_addr`/`mem_wdata` in cycle N+1, for exactly one cycle.
- **Padding:** pad writes follow the last data write back-to-back with no gap cycle.
- **`done`:** rises in the same cycle as the final write (data or pad) is presented on `mem_we`.
- **`busy`:** falls one cycle after the final `mem_we`.
- **`byte_ready`:** combinational from state only; it does not depend on `byte_valid`.
- **Throughput:** one byte per cycle, with no bubbles while `byte_valid` stays high.
- **Reset during LOAD/PAD:**
  - Next cycle is IDLE, with `mem_we=0`; a pending registered write is dropped.
  - All counters return to 0.
  - Memory contents are left as written.

## Structure
- Shared package:
  - State enum (IDLE, LOAD, PAD, DONE).
  - `NOP_BYTE` = 8'h00.
  - `WORD_BYTES` = 4.
- No sub-module. The FSM, the write pointer and the registered write port are a single module.

## Test plan
- **Aligned load:** `start`, then 8 bytes 0x24,0x01,0x00,0x05,0x00,0x00,0x00,0x00 with `byte_last` on the 8th → `mem_we` at addr 0..7 with these bytes, no pad, `done=1`, `byte_count=8`, `cpu_hold` falls one cycle after the addr-7 write.
- **Padding:** 5 bytes 0xAA..0xAE with `byte_last` on the 5th → addr 0..4 get the data and addr 5..7 get 0x00 on consecutive cycles, `byte_count=5`.
- **Backpressure/gaps:** 4 bytes with `byte_valid` toggled 1,0,0,1,1,0,1 → exactly 4 writes at addr 0..3 in acceptance order, and no `mem_we` on idle cycles.
- **Overflow:** 513 bytes with no `byte_last` → 512 writes at addr 0..511, `overflow=1`, `done=1`, `byte_ready=0` from the cycle after the 512th accept, and the 513th byte is not accepted.
- **Reset mid-load:** `reset` after 3 accepts → IDLE on the next cycle, `mem_we=0`, `byte_count=0`; a new `start` rewrites from addr 0.
- **Restart from DONE:** `start` while `done=1` → `done` clears the next cycle and a 4-byte load writes addr 0..3.
